control_tx_network_arbiter: RTL
===============================

# control_tx_network_arbiter

Packet-atomic two-way arbiter that shares the single network transmit stream toward the receptionist/network stack between the control block's KIP channel (kernel-to-kernel control messages) and LAN channel (host-facing LAN responses). It sits on the transmit side of the control API, mirroring the receive network bridge. It grants one channel at a time, holds the grant until that packet's `tlast` beat completes, and applies round-robin or strict-KIP priority. It also keeps per-channel transmitted-packet counters for debug.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 512, tdata width of all streams
- `AXIS_KEEP_WIDTH`, 64, tkeep width (`AXIS_DATA_WIDTH/8`)
- `IP_ADDRESS_WIDTH`, 32, destination IP width carried in tuser
- `IP_PORT_WIDTH`, 16, destination port width carried in tdest
- `PKT_CNT_WIDTH`, 32, width of per-channel packet counters

Ports (the clock is `i_clk`; the reset is `i_ap_rst_n`, asynchronous and active-low):
- `i_clk` in 1: single clock
- `i_ap_rst_n` in 1: asynchronous active-low reset
- `i_kip_priority` in 1: 1 = strict priority to KIP, 0 = round-robin; sampled only in IDLE
- `from_kip_tvalid/tready/tdata/tkeep/tlast` in/out/in/in/in 1/1/DATA/KEEP/1: KIP request stream
- `from_kip_tdest` in `IP_PORT_WIDTH`: destination port; `from_kip_tuser` in `IP_ADDRESS_WIDTH`: destination IP
- `from_lan_tvalid/tready/tdata/tkeep/tlast/tdest/tuser`: LAN request stream, same widths as KIP
- `to_net_tvalid/tready/tdata/tkeep/tlast/tdest/tuser` out/in/out/out/out/out/out: merged network stream
- `o_grant` out 2: one-hot current grant ({LAN, KIP}); 0 in IDLE
- `o_kip_pkt_cnt`, `o_lan_pkt_cnt` out `PKT_CNT_WIDTH`: completed packets per channel

## Operation
- FSM states: IDLE, GRANT_KIP, GRANT_LAN. There is a 1-bit round-robin pointer `rr_last` (0 = KIP served last, 1 = LAN served last).
- IDLE: all `from_*_tready` = 0 and `to_net_tvalid` = 0.
  - Only KIP valid -> GRANT_KIP. Only LAN valid -> GRANT_LAN.
  - Both valid with `i_kip_priority` = 1 -> GRANT_KIP.
  - Both valid with `i_kip_priority` = 0 -> grant the channel not served last (`rr_last` = 0 -> LAN, 1 -> KIP).
  - Neither valid -> stay in IDLE.
- GRANT_x: `to_net_*` = `from_x_*` (combinational mux covering tvalid, tdata, tkeep, tlast, tdest, tuser). `from_x_tready` = `to_net_tready`. The other channel's tready = 0.
- A beat transfers when `to_net_tvalid` & `to_net_tready`. On a beat with tlast = 1:
  - return to IDLE;
  - set `rr_last` to x;
  - increment x's packet counter.
- The grant is never revoked mid-packet, whatever happens on the other channel or on `i_kip_priority`.
- Packet counters wrap modulo 2^`PKT_CNT_WIDTH` and do not saturate.
- No data is buffered. The arbiter never drops, reorders or alters beats, tdest or tuser.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `rr_last` = 1 (so KIP wins the first contested round-robin grant);
  - counters = 0, `o_grant` = 0;
  - all tready = 0, `to_net_tvalid` = 0, `to_net_tlast` = 0.
  - `to_net_tdata/tkeep/tdest/tuser` are driven 0 while in IDLE.
- Reset asserted mid-packet: the partial packet is abandoned. After reset release the arbiter restarts from IDLE with no memory of the old grant.
- Latency: the cycle an input first raises tvalid with the arbiter in IDLE is cycle 0; grant registers at the cycle-0 edge; `to_net_tvalid` first goes high in cycle 1.
- Exactly one IDLE bubble cycle follows every packet's tlast beat, including back-to-back packets on the same channel.
- A single-beat packet (tlast on its first beat) occupies 1 grant cycle plus 1 IDLE cycle.
- Backpressure: with `to_net_tready` = 0 the granted channel's tready is 0 and the state holds. Outputs follow the source, which must hold them per AXI-Stream rules.
- `o_grant` and the counters are registered. A counter updates on the edge that completes the tlast beat.

## Test plan
- Single KIP packet: 1 beat, tdata[31:0]=`'hFFFFEEEE`, tdest=`'hABCD`, tuser=`'h0A030705`, tlast=1, tready=1 -> `to_net_tvalid` high exactly in cycle 1 with identical tdata/tdest/tuser; `o_kip_pkt_cnt`=1; LAN count stays 0.
- Round-robin contention: `i_kip_priority`=0, both channels continuously offer 2-beat packets -> grant order KIP, LAN, KIP, LAN with one IDLE cycle between packets; after 8 packets each counter = 4.
- Strict priority: `i_kip_priority`=1, both channels continuously valid -> only KIP is granted and LAN tready stays 0. Drop KIP tvalid -> LAN granted on the next IDLE edge.
- Packet atomicity under backpressure: LAN 3-beat packet granted, `to_net_tready` toggling 1,0,0,1,1; KIP asserts valid mid-packet -> all 3 LAN beats are emitted contiguously and unmodified, KIP is granted only after the LAN tlast beat, and `o_lan_pkt_cnt` increments by exactly 1.
- Reset mid-packet: assert `i_ap_rst_n`=0 during beat 2 of a 4-beat KIP packet -> outputs go to reset values in the same cycle without waiting for a clock edge and counters = 0. After release, the next contested round-robin grant goes to KIP.
- Counter wrap: force/preload `o_kip_pkt_cnt` = `'hFFFFFFFF`, then send one KIP packet -> the counter reads 0.

Source files
------------

// File: rtl/control_tx_network_arbiter.sv
// control_tx_network_arbiter
//
// Packet-atomic two-way arbiter for the control block's network transmit path.
// Two AXI-Stream sources share one network stream toward the receptionist /
// network stack:
// - KIP: kernel-to-kernel control messages.
// - LAN: host-facing LAN responses.
//
// A grant is taken only from IDLE and is held until the granted packet's tlast
// beat transfers. After that beat the arbiter always spends one cycle in IDLE
// before it grants again. The grant goes to KIP under strict priority, or
// otherwise by round-robin. Nothing is buffered: the granted source is muxed
// straight through to the network stream.
//
// Ports:
//   i_clk, i_ap_rst_n    clock; asynchronous active-low reset
//   i_kip_priority       1 = strict KIP priority, 0 = round-robin (sampled in IDLE)
//   from_kip_*           KIP request stream (tvalid/tready/tdata/tkeep/tlast/tdest/tuser)
//   from_lan_*           LAN request stream (same fields as KIP)
//   to_net_*             merged network stream
//   o_grant              registered one-hot grant {LAN, KIP}; 0 in IDLE
//   o_kip_pkt_cnt        completed KIP packets (wraps)
//   o_lan_pkt_cnt        completed LAN packets (wraps)

module control_tx_network_arbiter #(
    parameter int unsigned AXIS_DATA_WIDTH  = 512,
    parameter int unsigned AXIS_KEEP_WIDTH  = 64,
    parameter int unsigned IP_ADDRESS_WIDTH = 32,
    parameter int unsigned IP_PORT_WIDTH    = 16,
    parameter int unsigned PKT_CNT_WIDTH    = 32
) (
    input  logic                        i_clk,
    input  logic                        i_ap_rst_n,
    input  logic                        i_kip_priority,

    input  logic                        from_kip_tvalid,
    output logic                        from_kip_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]  from_kip_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]  from_kip_tkeep,
    input  logic                        from_kip_tlast,
    input  logic [IP_PORT_WIDTH-1:0]    from_kip_tdest,
    input  logic [IP_ADDRESS_WIDTH-1:0] from_kip_tuser,

    input  logic                        from_lan_tvalid,
    output logic                        from_lan_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]  from_lan_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]  from_lan_tkeep,
    input  logic                        from_lan_tlast,
    input  logic [IP_PORT_WIDTH-1:0]    from_lan_tdest,
    input  logic [IP_ADDRESS_WIDTH-1:0] from_lan_tuser,

    output logic                        to_net_tvalid,
    input  logic                        to_net_tready,
    output logic [AXIS_DATA_WIDTH-1:0]  to_net_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]  to_net_tkeep,
    output logic                        to_net_tlast,
    output logic [IP_PORT_WIDTH-1:0]    to_net_tdest,
    output logic [IP_ADDRESS_WIDTH-1:0] to_net_tuser,

    output logic [1:0]                  o_grant,
    output logic [PKT_CNT_WIDTH-1:0]    o_kip_pkt_cnt,
    output logic [PKT_CNT_WIDTH-1:0]    o_lan_pkt_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StGrantKip,
        StGrantLan
    } state_e;

    state_e                   state_q;
    // 0 = KIP served last, 1 = LAN served last.
    logic                     rr_last_q;
    logic [1:0]               grant_q;
    logic [PKT_CNT_WIDTH-1:0] kip_cnt_q;
    logic [PKT_CNT_WIDTH-1:0] lan_cnt_q;

    logic kip_wins;
    logic lan_wins;
    logic beat;
    logic pkt_done;

    // IDLE arbitration. KIP wins if it is alone, if strict priority is set,
    // or if LAN was served last. LAN wins whenever it is valid and KIP does not.
    always_comb begin
        kip_wins = from_kip_tvalid &
                   (~from_lan_tvalid | i_kip_priority | rr_last_q);
        lan_wins = from_lan_tvalid & ~kip_wins;
    end

    // Pass-through mux. In IDLE every output is held at 0, so no beat can
    // leak out before a grant has been registered.
    always_comb begin
        to_net_tvalid   = 1'b0;
        to_net_tdata    = '0;
        to_net_tkeep    = '0;
        to_net_tlast    = 1'b0;
        to_net_tdest    = '0;
        to_net_tuser    = '0;
        from_kip_tready = 1'b0;
        from_lan_tready = 1'b0;
        unique case (state_q)
            StGrantKip: begin
                to_net_tvalid   = from_kip_tvalid;
                to_net_tdata    = from_kip_tdata;
                to_net_tkeep    = from_kip_tkeep;
                to_net_tlast    = from_kip_tlast;
                to_net_tdest    = from_kip_tdest;
                to_net_tuser    = from_kip_tuser;
                from_kip_tready = to_net_tready;
            end
            StGrantLan: begin
                to_net_tvalid   = from_lan_tvalid;
                to_net_tdata    = from_lan_tdata;
                to_net_tkeep    = from_lan_tkeep;
                to_net_tlast    = from_lan_tlast;
                to_net_tdest    = from_lan_tdest;
                to_net_tuser    = from_lan_tuser;
                from_lan_tready = to_net_tready;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        beat     = to_net_tvalid & to_net_tready;
        pkt_done = beat & to_net_tlast;
    end

    // Control FSM. The grant and the counters are registered alongside the
    // state, so they change on the same edge as the state does.
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b1;
            grant_q   <= 2'b00;
            kip_cnt_q <= '0;
            lan_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (kip_wins) begin
                        state_q <= StGrantKip;
                        grant_q <= 2'b01;
                    end else if (lan_wins) begin
                        state_q <= StGrantLan;
                        grant_q <= 2'b10;
                    end
                end
                StGrantKip: begin
                    if (pkt_done) begin
                        state_q   <= StIdle;
                        grant_q   <= 2'b00;
                        rr_last_q <= 1'b0;
                        kip_cnt_q <= kip_cnt_q + PKT_CNT_WIDTH'(1);
                    end
                end
                StGrantLan: begin
                    if (pkt_done) begin
                        state_q   <= StIdle;
                        grant_q   <= 2'b00;
                        rr_last_q <= 1'b1;
                        lan_cnt_q <= lan_cnt_q + PKT_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        o_grant       = grant_q;
        o_kip_pkt_cnt = kip_cnt_q;
        o_lan_pkt_cnt = lan_cnt_q;
    end

    // The registered grant must always agree with the state.
    grant_tracks_state: assert property (
        @(posedge i_clk) disable iff (!i_ap_rst_n)
        (grant_q == 2'b00) == (state_q == StIdle)
    );

    // A granted channel may not be ready while the sink is stalled.
    no_ready_without_sink: assert property (
        @(posedge i_clk) disable iff (!i_ap_rst_n)
        !to_net_tready |-> !(from_kip_tready | from_lan_tready)
    );

endmodule
